// File: rtl/video_axis_pkg.sv
// Shared types and helpers for the native-video to AXI4-Stream bridge.
//   vaxis_state_t : framing state machine encoding
//   SIDEBAND_W    : extra FIFO bits per pixel ({sof, eol})
//   fifo_addr_w() : pointer width for a power-of-two FIFO depth
package video_axis_pkg;

  typedef enum logic [1:0] {
    WAIT_VS  = 2'd0,
    WAIT_SOF = 2'd1,
    ACTIVE   = 2'd2,
    DROP     = 2'd3
  } vaxis_state_t;

  localparam int SIDEBAND_W = 2;

  function automatic int fifo_addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/video_axis_fifo.sv
// Synchronous show-ahead FIFO for the pixel path.
//   pclk, prst_n : clock, asynchronous active-low reset
//   wr_en, wdata : push side; a push while full is accepted only if a pop
//                  happens in the same cycle
//   full         : FIFO_DEPTH words stored
//   rd_en, rdata : pop side; rdata shows the head word whenever !empty
//   empty        : no words stored
module video_axis_fifo
  import video_axis_pkg::*;
#(
  parameter int DSIZE      = 26,
  parameter int FIFO_DEPTH = 512
) (
  input  logic             pclk,
  input  logic             prst_n,
  input  logic             wr_en,
  input  logic [DSIZE-1:0] wdata,
  output logic             full,
  input  logic             rd_en,
  output logic [DSIZE-1:0] rdata,
  output logic             empty
);

  localparam int AW = fifo_addr_w(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic [DSIZE-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_wr, do_rd;

  always_comb begin
    do_rd    = rd_en & (cnt_q != '0);
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    do_wr    = wr_en & ((cnt_q != FULL_CNT) | do_rd);
    wr_ptr_d = wr_ptr_q + AW'(do_wr);
    rd_ptr_d = rd_ptr_q + AW'(do_rd);
    cnt_d    = cnt_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset; only the pointers define which words are live.
  always_ff @(posedge pclk) begin
    if (do_wr) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  // Combinational head read: a word pushed into an empty FIFO is visible next cycle.
  assign rdata = mem[rd_ptr_q];
  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/video_native_to_axis.sv
// Native video (vsync/hsync/de/data) to AXI4-Stream video (tuser=SOF, tlast=EOL).
// Optional line-length checker: define VIDEO_AXIS_CHECK_EN.
//   pclk, prst_n         : pixel clock, asynchronous active-low reset
//   enable               : 0 drops all input and parks the framer in WAIT_VS
//   vsync, hsync, de     : native timing (hsync is not used for framing)
//   data                 : pixel, valid when de=1
//   hactive              : expected pixels per line (checker only)
//   axis_tdata/tvalid/tready/tuser/tlast : AXI4-Stream master
//   overflow             : sticky, a push hit a full FIFO and the frame was dropped
//   frame_cnt            : frames fully accepted into the FIFO, wraps
//   line_err             : sticky line-length error (0 without the checker)
module video_native_to_axis
  import video_axis_pkg::*;
#(
  parameter int DSIZE      = 24,
  parameter int FIFO_DEPTH = 512,
  parameter bit VS_POL     = 1'b1
) (
  input  logic             pclk,
  input  logic             prst_n,
  input  logic             enable,
  input  logic             vsync,
  input  logic             hsync,
  input  logic             de,
  input  logic [DSIZE-1:0] data,
  input  logic [15:0]      hactive,
  output logic [DSIZE-1:0] axis_tdata,
  output logic             axis_tvalid,
  input  logic             axis_tready,
  output logic             axis_tuser,
  output logic             axis_tlast,
  output logic             overflow,
  output logic [15:0]      frame_cnt,
  output logic             line_err
);

  localparam int FW = DSIZE + SIDEBAND_W;

  vaxis_state_t     state_q, state_d;
  logic             vs_act, vs_rise, vs_act_q;
  logic [DSIZE-1:0] hold_q, hold_d;
  logic             hold_sof_q, hold_sof_d;
  logic             hold_vld_q, hold_vld_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             push, push_eol, pop, drop, frame_done;
  logic             fifo_full, fifo_empty;
  logic [FW-1:0]    fifo_wdata, fifo_rdata;
  logic             unused_inputs;

  assign unused_inputs = ^{hsync, hactive};

  assign vs_act  = (vsync == VS_POL);
  assign vs_rise = vs_act & ~vs_act_q;
  assign pop     = ~fifo_empty & axis_tready;

  // Framing: a pixel sits in the hold register until the next input event
  // tells us whether it ends the line (de low, vsync, disable) or not.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    hold_sof_d = hold_sof_q;
    hold_vld_d = hold_vld_q;
    push       = 1'b0;
    push_eol   = 1'b0;
    frame_done = 1'b0;

    if (!enable) begin
      push       = hold_vld_q;
      push_eol   = 1'b1;
      hold_vld_d = 1'b0;
      state_d    = WAIT_VS;
    end else begin
      unique case (state_q)
        WAIT_VS, DROP: begin
          if (vs_rise) state_d = WAIT_SOF;
        end
        WAIT_SOF: begin
          if (de) begin
            hold_d     = data;
            hold_sof_d = 1'b1;
            hold_vld_d = 1'b1;
            state_d    = ACTIVE;
          end
        end
        ACTIVE: begin
          if (vs_rise) begin
            // Close the frame; it counts even if its last line already ended.
            push       = hold_vld_q;
            push_eol   = 1'b1;
            hold_vld_d = 1'b0;
            frame_done = 1'b1;
            state_d    = WAIT_SOF;
          end else if (de) begin
            push       = hold_vld_q;
            push_eol   = 1'b0;
            hold_d     = data;
            hold_sof_d = 1'b0;
            hold_vld_d = 1'b1;
          end else if (hold_vld_q) begin
            push       = 1'b1;
            push_eol   = 1'b1;
            hold_vld_d = 1'b0;
          end
        end
        default: state_d = WAIT_VS;
      endcase
    end

    // A push the FIFO cannot take loses the frame; disable still wins the state.
    drop = push & fifo_full & ~pop;
    if (drop) begin
      hold_vld_d = 1'b0;
      frame_done = 1'b0;
      if (enable) state_d = DROP;
    end

    overflow_d  = overflow_q | drop;
    frame_cnt_d = frame_cnt_q + 16'(frame_done);
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state_q     <= WAIT_VS;
      vs_act_q    <= 1'b0;
      hold_q      <= '0;
      hold_sof_q  <= 1'b0;
      hold_vld_q  <= 1'b0;
      overflow_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      vs_act_q    <= vs_act;
      hold_q      <= hold_d;
      hold_sof_q  <= hold_sof_d;
      hold_vld_q  <= hold_vld_d;
      overflow_q  <= overflow_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign fifo_wdata = {hold_sof_q, push_eol, hold_q};

  video_axis_fifo #(
    .DSIZE      (FW),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .pclk   (pclk),
    .prst_n (prst_n),
    .wr_en  (push),
    .wdata  (fifo_wdata),
    .full   (fifo_full),
    .rd_en  (pop),
    .rdata  (fifo_rdata),
    .empty  (fifo_empty)
  );

  // Payload is forced to 0 while empty so stale RAM contents never show.
  assign axis_tvalid = ~fifo_empty;
  assign axis_tdata  = fifo_empty ? '0 : fifo_rdata[DSIZE-1:0];
  assign axis_tlast  = ~fifo_empty & fifo_rdata[DSIZE];
  assign axis_tuser  = ~fifo_empty & fifo_rdata[DSIZE+1];
  assign overflow    = overflow_q;
  assign frame_cnt   = frame_cnt_q;

`ifdef VIDEO_AXIS_CHECK_EN
  logic        de_q;
  logic [15:0] pix_cnt_q, pix_cnt_d;
  logic        line_err_q, line_err_d;

  // Counts accepted pixels per line; lines already in DROP are not judged.
  always_comb begin
    pix_cnt_d  = pix_cnt_q;
    line_err_d = line_err_q;
    if (de_q & ~de) begin
      if ((state_q == ACTIVE) && (pix_cnt_q != hactive)) line_err_d = 1'b1;
      pix_cnt_d = '0;
    end else if (enable && de && ((state_q == WAIT_SOF) || (state_q == ACTIVE))) begin
      pix_cnt_d = pix_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      de_q       <= 1'b0;
      pix_cnt_q  <= '0;
      line_err_q <= 1'b0;
    end else begin
      de_q       <= de;
      pix_cnt_q  <= pix_cnt_d;
      line_err_q <= line_err_d;
    end
  end

  assign line_err = line_err_q;
`else
  assign line_err = 1'b0;
`endif

endmodule
